// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_pkg                                                          |
// | State encoding, opcode/funct fields and ALU codes for mc_ctrl_fsm.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mc_ctrl_pkg;

    localparam logic [3:0] ST_HOLD     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_EXEC_R   = 4'd3;
    localparam logic [3:0] ST_R_WB     = 4'd4;
    localparam logic [3:0] ST_EXEC_I   = 4'd5;
    localparam logic [3:0] ST_I_WB     = 4'd6;
    localparam logic [3:0] ST_MEM_ADDR = 4'd7;
    localparam logic [3:0] ST_MEM_RD   = 4'd8;
    localparam logic [3:0] ST_MEM_WB   = 4'd9;
    localparam logic [3:0] ST_MEM_WR   = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_ILLEGAL  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] ALU_SRC_B_REG = 2'd0;
    localparam logic [1:0] ALU_SRC_B_IMM = 2'd1;
    localparam logic [1:0] ALU_SRC_B_ONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ctrl_dec                                                         |
// | Combinational R-type funct decode to ALU operation plus legality.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_legal
);

    always_comb begin
        alu_ctrl    = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_fsm                                                          |
// | Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic       ir_we,
    output logic       ab_we,
    output logic       aluout_we,
    output logic       pc_inc,
    output logic       pc_we,
    output logic       pc_src,
    output logic       gr_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       dmem_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [3:0] c_hold_last = 4'(RESET_HOLD - 1);

    logic [3:0] r_state;
    logic [3:0] r_hold_cnt;
    logic [2:0] w_dec_alu_ctrl;
    logic       w_funct_legal;

    alu_ctrl_dec u_alu_ctrl_dec (
        .funct       (funct),
        .alu_ctrl    (w_dec_alu_ctrl),
        .funct_legal (w_funct_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) r_state <= ST_FETCH;
                    else                           r_hold_cnt <= r_hold_cnt + 4'd1;
                end
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     r_state <= w_funct_legal ? ST_EXEC_R : ST_ILLEGAL;
                        OP_LW, OP_SW: r_state <= ST_MEM_ADDR;
                        OP_ADDI:      r_state <= ST_EXEC_I;
                        OP_BEQ:       r_state <= ST_BRANCH;
                        OP_J:         r_state <= ST_JUMP;
                        default:      r_state <= ST_ILLEGAL;
                    endcase
                end
                ST_EXEC_R:   r_state <= ST_R_WB;
                ST_EXEC_I:   r_state <= ST_I_WB;
                ST_MEM_ADDR: r_state <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   r_state <= ST_MEM_WB;
                // Every terminal state, and any unused encoding, restarts at FETCH.
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        aluout_we  = 1'b0;
        pc_inc     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        gr_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        dmem_we    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_SRC_B_REG;
        alu_ctrl   = ALU_ADD;
        illegal_op = 1'b0;
        case (r_state)
            ST_FETCH: begin
                ir_we  = 1'b1;
                pc_inc = 1'b1;
            end
            // Branch target PC+1+imm is computed here and kept in ALUOut.
            ST_DECODE: begin
                ab_we     = 1'b1;
                aluout_we = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = w_dec_alu_ctrl;
                aluout_we = 1'b1;
            end
            ST_R_WB: begin
                gr_we   = 1'b1;
                reg_dst = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
                aluout_we = 1'b1;
            end
            ST_I_WB: gr_we = 1'b1;
            ST_MEM_WB: begin
                gr_we      = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: dmem_we = 1'b1;
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_we     = alu_zero;
            end
            ST_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 1'b1;
            end
            ST_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_ctrl_fsm                                                       |
// | Directed plus random instruction streams against a cycle model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mc_ctrl_fsm;

    localparam int unsigned HOLD_CYCLES = 3;

    logic       clk, rst;
    logic [5:0] opcode, funct;
    logic       alu_zero;
    logic       ir_we, ab_we, aluout_we, pc_inc, pc_we, pc_src, gr_we;
    logic       reg_dst, mem_to_reg, dmem_we, alu_src_a, illegal_op;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       ir_we, ab_we, aluout_we, pc_inc, pc_we, pc_src, gr_we;
        logic       reg_dst, mem_to_reg, dmem_we, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal_op;
    } outs_t;

    outs_t exp_q[$];
    outs_t care_q[$];
    logic [5:0] ftab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    mc_ctrl_fsm #(.RESET_HOLD(HOLD_CYCLES)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .ir_we(ir_we), .ab_we(ab_we), .aluout_we(aluout_we), .pc_inc(pc_inc),
        .pc_we(pc_we), .pc_src(pc_src), .gr_we(gr_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .dmem_we(dmem_we), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t pack_dut();
        return {ir_we, ab_we, aluout_we, pc_inc, pc_we, pc_src, gr_we, reg_dst,
                mem_to_reg, dmem_we, alu_src_a, alu_src_b, alu_ctrl, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit rfunct_ok(input logic [5:0] f);
        foreach (ftab[i]) if (ftab[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_known(input logic [5:0] o);
        return o inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    endfunction

    // Strobes are always compared; a select only where the step names it.
    function automatic outs_t strobes();
        outs_t m = '0;
        m.ir_we = 1; m.ab_we = 1; m.aluout_we = 1; m.pc_inc = 1; m.pc_we = 1;
        m.gr_we = 1; m.dmem_we = 1; m.illegal_op = 1;
        return m;
    endfunction

    // Expected per-cycle outputs for one instruction, FETCH up to the next FETCH.
    function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        outs_t e, c;
        logic [2:0] code = 3'd0;
        foreach (ftab[i]) if (ftab[i] == fn) code = 3'(i);
        exp_q.delete(); care_q.delete();
        e = '0; c = strobes(); e.ir_we = 1; e.pc_inc = 1;
        exp_q.push_back(e); care_q.push_back(c);
        e = '0; c = strobes(); e.ab_we = 1; e.aluout_we = 1; e.alu_src_b = 2'd1;
        c.alu_src_a = 1; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b111;
        exp_q.push_back(e); care_q.push_back(c);
        e = '0; c = strobes();
        if (op == 6'h00 && rfunct_ok(fn)) begin
            e.aluout_we = 1; e.alu_src_a = 1; e.alu_ctrl = code;
            c.alu_src_a = 1; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b111;
            exp_q.push_back(e); care_q.push_back(c);
            e = '0; c = strobes(); e.gr_we = 1; e.reg_dst = 1; c.reg_dst = 1; c.mem_to_reg = 1;
            exp_q.push_back(e); care_q.push_back(c);
        end else if (op inside {6'h08, 6'h23, 6'h2B}) begin
            e.aluout_we = 1; e.alu_src_a = 1; e.alu_src_b = 2'd1;
            c.alu_src_a = 1; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b111;
            exp_q.push_back(e); care_q.push_back(c);
            e = '0; c = strobes();
            if (op == 6'h2B) e.dmem_we = 1;
            else if (op == 6'h08) begin e.gr_we = 1; c.reg_dst = 1; c.mem_to_reg = 1; end
            exp_q.push_back(e); care_q.push_back(c);
            if (op == 6'h23) begin
                e = '0; c = strobes(); e.gr_we = 1; e.mem_to_reg = 1;
                c.reg_dst = 1; c.mem_to_reg = 1;
                exp_q.push_back(e); care_q.push_back(c);
            end
        end else if (op == 6'h04) begin
            e.alu_src_a = 1; e.alu_ctrl = 3'b001; e.pc_we = z;
            c.alu_src_a = 1; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b111; c.pc_src = 1;
            exp_q.push_back(e); care_q.push_back(c);
        end else if (op == 6'h02) begin
            e.pc_we = 1; e.pc_src = 1; c.pc_src = 1;
            exp_q.push_back(e); care_q.push_back(c);
        end else begin
            e.illegal_op = 1;
            exp_q.push_back(e); care_q.push_back(c);
        end
    endfunction

    task automatic check_cycle(input string tag, input outs_t e, input outs_t c);
        outs_t a = pack_dut();
        chk({tag, " outs"}, 32'(a & c), 32'(e & c));
        chk({tag, " one_we"}, 32'($countones({ir_we, gr_we, dmem_we}) <= 1), 32'd1);
        chk({tag, " pc_excl"}, 32'(pc_inc & pc_we), 32'd0);
    endtask

    // Runs an instruction; stop_at < 0 checks every cycle, else only the first stop_at.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int stop_at);
        int n;
        opcode = op; funct = fn; alu_zero = z;
        model(op, fn, z);
        n = (stop_at < 0) ? exp_q.size() : stop_at;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check_cycle($sformatf("%s c%0d", tag, k + 1), exp_q[k], care_q[k]);
            if (k == 0) chk({tag, " fetch_state"}, 32'(state_o), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " outs"}, 32'(pack_dut()), 32'd0);
        chk({tag, " state"}, 32'(state_o), 32'd0);
    endtask

    // Called at posedge+1 with rst high; releases it and checks the hold window.
    task automatic release_and_hold();
        rst = 1'b0;
        check_idle("hold1");
        for (int i = 1; i < int'(HOLD_CYCLES); i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("hold%0d", i + 1));
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        logic       z;
        rst = 1'b1; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("in_reset");
        release_and_hold();

        run_instr("r_sub",    6'h00, 6'h22, 1'b0, -1);
        run_instr("r_slt",    6'h00, 6'h2A, 1'b1, -1);
        run_instr("addi",     6'h08, 6'h11, 1'b0, -1);
        run_instr("lw",       6'h23, 6'h00, 1'b0, -1);
        run_instr("sw",       6'h2B, 6'h3F, 1'b1, -1);
        run_instr("beq_t",    6'h04, 6'h00, 1'b1, -1);
        run_instr("beq_nt",   6'h04, 6'h00, 1'b0, -1);
        run_instr("j",        6'h02, 6'h05, 1'b1, -1);
        run_instr("ill_op",   6'h3F, 6'h20, 1'b0, -1);
        run_instr("ill_fn",   6'h00, 6'h07, 1'b0, -1);

        // Reset during MEM_RD of a load: the pending write-back must never appear.
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 4);
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        repeat (2) begin
            @(posedge clk); #1;
            check_idle("rst_held");
        end
        release_and_hold();
        run_instr("after_rst", 6'h00, 6'h25, 1'b0, -1);

        for (int t = 0; t < 150; t++) begin
            fn = 6'($urandom);
            z  = 1'($urandom);
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = ftab[$urandom_range(0, 4)]; end
                1: begin op = 6'h00; if (rfunct_ok(fn)) fn = 6'h07; end
                2: op = 6'h08;
                3: op = 6'h23;
                4: op = 6'h2B;
                5: op = 6'h04;
                6: op = 6'h02;
                default: begin op = 6'($urandom); if (op_known(op)) op = 6'h3F; end
            endcase
            run_instr($sformatf("rnd%0d_op%02h_fn%02h", t, op, fn), op, fn, z, -1);
        end
        run_instr("final", 6'h02, 6'h00, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
